// File: rtl/address_encoder_pkg.sv
// -----------------------------------------------------------------------------
// address_encoder_pkg
// Purpose : shared constants and FSM state type for the address encoder
//           arbiter slice (address_encoder_arb, prio_pick, bus interface).
// Ports   : none (package).
// Config  : ADDRESS_ENCODER_RR_EN selects round-robin (defined) or fixed
//           priority (undefined) inside address_encoder_arb.
// -----------------------------------------------------------------------------
package address_encoder_pkg;

  localparam int NUM_REQ = 8;
  localparam int ADDR_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : address_encoder_pkg

// File: rtl/address_encoder_arb_if.sv
// -----------------------------------------------------------------------------
// address_encoder_arb_if
// Purpose : request/grant bus between requesters/consumer and the arbiter.
// Signals : req[0:7]     request lines, bit i = requester i
//           en           grant enable (new grants only)
//           ack          consumer accepts the current grant
//           address[0:2] granted index, address[0] = LSB
//           grant[0:7]   one-hot copy of address, zero when not valid
//           valid        address/grant hold a live grant
// Modports: master drives req/en/ack; slave (the arbiter) drives the rest.
// Config  : none (ADDRESS_ENCODER_RR_EN only affects address_encoder_arb).
// -----------------------------------------------------------------------------
interface address_encoder_arb_if;
  import address_encoder_pkg::*;

  logic [0:NUM_REQ-1] req;
  logic               en;
  logic               ack;
  logic [0:ADDR_W-1]  address;
  logic [0:NUM_REQ-1] grant;
  logic               valid;

  modport master (
    output req, en, ack,
    input  address, grant, valid
  );

  modport slave (
    input  req, en, ack,
    output address, grant, valid
  );

endinterface : address_encoder_arb_if

// File: rtl/prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Purpose : combinational rotate-and-find-first. Searches vec ascending from
//           index start, wrapping NUM_REQ-1 -> 0; the first set bit wins.
// Ports   : vec   [NUM_REQ-1:0] candidate vector
//           start [ADDR_W-1:0]  first index examined
//           idx   [ADDR_W-1:0]  winning index (0 when nothing found)
//           found               at least one bit of vec is set
// Config  : none.
// -----------------------------------------------------------------------------
module prio_pick
  import address_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [ADDR_W-1:0]  start,
  output logic [ADDR_W-1:0]  idx,
  output logic               found
);

  logic [ADDR_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest set bit is the
  // last assignment; ADDR_W-bit addition gives the wrap for free.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + ADDR_W'(k);
      if (vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule : prio_pick

// File: rtl/address_encoder_arb.sv
// -----------------------------------------------------------------------------
// address_encoder_arb
// Purpose : captures requests into a pending vector and grants one requester
//           at a time. A grant is held stable until ack, then one bubble
//           cycle (valid=0) separates consecutive grants.
// Ports   : clk    single clock, rising edge
//           rst_n  synchronous, active-low reset
//           bus    address_encoder_arb_if.slave (req/en/ack in,
//                  address/grant/valid out)
// Config  : ADDRESS_ENCODER_RR_EN defined   -> round-robin, search starts one
//                                              past the last accepted index.
//           ADDRESS_ENCODER_RR_EN undefined -> fixed priority from index 0.
// -----------------------------------------------------------------------------
module address_encoder_arb
  import address_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  address_encoder_arb_if.slave bus
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic               valid_q, valid_d;

  logic [NUM_REQ-1:0] req_v;
  logic [ADDR_W-1:0]  start;
  logic [ADDR_W-1:0]  pick_idx;
  logic               pick_found;

  // The bus uses ascending ranges; internally everything is [N-1:0] with
  // bit i meaning requester i / address bit i.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_map
    assign req_v[gi]     = bus.req[gi];
    assign bus.grant[gi] = grant_q[gi];
  end

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_map
    assign bus.address[gi] = address_q[gi];
  end

  assign bus.valid = valid_q;

`ifdef ADDRESS_ENCODER_RR_EN
  logic [ADDR_W-1:0] last_q, last_d;

  // last resets to the top index so index 0 is searched first after reset.
  assign start = last_q + ADDR_W'(1);
`else
  assign start = '0;
`endif

  // Same-cycle requests are included so a fresh request is granted at the
  // very edge that captures it.
  prio_pick u_pick (
    .vec   (pending_q | req_v),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req_v;
    grant_d   = grant_q;
    address_d = address_q;
    valid_d   = valid_q;
`ifdef ADDRESS_ENCODER_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en && pick_found) begin
          address_d          = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          valid_d            = 1'b1;
          state_d            = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          // A request arriving with the accept re-arms the same bit.
          pending_d[address_q] = req_v[address_q];
          grant_d              = '0;
          valid_d              = 1'b0;
          state_d              = IDLE;
`ifdef ADDRESS_ENCODER_RR_EN
          last_d               = address_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      address_q <= '0;
      valid_q   <= 1'b0;
`ifdef ADDRESS_ENCODER_RR_EN
      last_q    <= ADDR_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      address_q <= address_d;
      valid_q   <= valid_d;
`ifdef ADDRESS_ENCODER_RR_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule : address_encoder_arb
